byte_fifo: RTL and testbench
============================

// Module: byte_fifo
// PURPOSE
//  Synchronous byte FIFO with valid/ready handshake on both sides.
//  Sits directly upstream of the byte-register stage and supplies its 8-bit data operand.
//  Absorbs bursts from the producer and decouples producer stalls from the consumer.
//  Registered storage; no combinational path from in_* to out_*.
// PARAMETERS
//  WIDTH  8  data width in bits
//  DEPTH  4  number of entries; power of two, >= 2
// PORTS
//  clk        input   1                    rising-edge clock, single clock domain
//  rst        input   1                    synchronous, active-high reset
//  in_valid   input   1                    producer offers in_data this cycle
//  in_ready   output  1                    FIFO accepts a word this cycle
//  in_data    input   WIDTH                write data
//  out_valid  output  1                    out_data holds the head entry
//  out_ready  input   1                    consumer takes the head entry this cycle
//  out_data   output  WIDTH                head entry
//  count      output  $clog2(DEPTH)+1      current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset:
//  - Reset is clocked: rst high at a rising edge clears wr_ptr, rd_ptr and count to 0.
//  - After reset: out_valid=0, out_data=0, count=0.
//  - in_ready=0 in every cycle rst is high; it rises the cycle after rst falls.
//  - Storage array is not reset.
//  Transfers:
//  - push = in_valid & in_ready.
//  - pop = out_valid & out_ready.
//  - Both take effect at the rising edge.
//  Ready and valid:
//  - in_ready = !rst & (count != DEPTH). It does not depend on out_ready, so there is no full-bypass.
//  - out_valid = (count != 0).
//  - out_data = mem[rd_ptr] when out_valid, else 0.
//  Latency:
//  - A word pushed at edge N is visible with out_valid=1 after edge N.
//  - Minimum 1 cycle. No empty-bypass.
//  Pointers:
//  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap DEPTH-1 -> 0.
//  - Full and empty are decided by count, never by pointer compare.
//  Count:
//  - push & !pop -> +1
//  - pop & !push -> -1
//  - both or neither -> unchanged
//  - Saturation cannot occur because ready and valid gate each side.
//  Simultaneous push and pop:
//  - Legal at any 0 < count < DEPTH.
//  - At count==DEPTH only a pop can occur (in_ready=0). Count drops to DEPTH-1 and in_ready rises next cycle.
//  - At count==0 only a push can occur.
//  Ordering: strict FIFO. Data is never dropped or duplicated.
//  Protocol:
//  - Inputs are sampled only at clock edges.
//  - The producer may change in_data freely while in_valid=0.
//  - Once out_valid=1, out_data is stable until popped or reset.
//  Reset mid-operation:
//  - All held data is discarded.
//  - A push and a pop coinciding with an asserted rst are both ignored.
// STRUCTURE
//  Shared package fifo_pkg:
//  - typedef logic [7:0] byte_t
//  - localparam FIFO_DEPTH_DEFAULT = 4
//  Sub-module fifo_ptr:
//  - Holds wr_ptr, rd_ptr and count.
//  - Takes push/pop and produces full/empty.
//  - Instanced once.
//  - The top level holds the storage array and the read mux.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0 throughout; in_ready=1 after rst falls.
//  2. Single word: push 8'hA5 at edge N -> out_valid=1, out_data=8'hA5, count=1 after N; pop -> count=0, out_data=0.
//  3. Fill/full: push 8'h01..8'h04 with out_ready=0 -> count=4, in_ready=0; a fifth in_valid with 8'h05 is not accepted;
//     pops yield 01,02,03,04 in order.
//  4. Full + pop: at count=4, in_valid=1 and out_ready=1 -> one pop only, count=3, in_ready=1 next cycle.
//  5. Wrap and stream: in_valid=out_ready=1 for 20 cycles, data incrementing from 8'h10 -> output 8'h10.. in order,
//     count steady at 1, pointers wrap 5 times.
//  6. Mid-op reset: count=3, assert rst one cycle -> count=0, out_valid=0; old data never reappears after refill.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the byte FIFO and its pointer/occupancy tracker.
package fifo_pkg;

    typedef logic [7:0] byte_t;

    localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Write/read pointers and occupancy count for a power-of-two FIFO.
// Full and empty come from the count only, never from a pointer compare.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers wrap DEPTH-1 -> 0 naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);

endmodule : fifo_ptr

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with valid/ready on both sides; storage is registered,
// so nothing on the in_* side reaches out_* in the same cycle.
module byte_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    // Handshake: a word moves at a rising edge when valid & ready are both high
    // on that side. in_ready ignores out_ready (no full-bypass) and out_valid
    // ignores in_valid (no empty-bypass); both sides are frozen while rst is high.

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign in_ready  = !rst && !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !rst;

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Storage is deliberately left unreset; out_data masks it while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_ptr] <= in_data;
    end

    assign out_data = out_valid ? r_mem[w_rd_ptr] : '0;

endmodule : byte_fifo

// File: tb/tb_byte_fifo.sv
// Directed bench for byte_fifo: driver tasks push expected words into exp_q,
// a negedge monitor pops and compares whenever the DUT hands over a word.
module tb_byte_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    byte_t      in_data;
    logic       out_valid;
    logic       out_ready;
    byte_t      out_data;
    logic [2:0] count;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [7:0] exp_q[$];
    int         m_count = 0;
    int         n_vec   = 0;
    int         n_err   = 0;
    bit         mon_en  = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic cycle(input logic v, input byte_t d, input logic r, input logic rs);
        bit acc;
        bit pp;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        rst       = rs;
        @(negedge clk);
        check("in_ready",  {31'd0, in_ready},  {31'd0, (!rs && m_count != DEPTH)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (m_count != 0)});
        check("count",     {29'd0, count},     m_count);
        @(posedge clk);
        if (rs) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            acc = v && (m_count != DEPTH);
            pp  = r && (m_count != 0);
            if (acc) exp_q.push_back(d);
            m_count = m_count + int'(acc) - int'(pp);
        end
        #1;
    endtask

    // monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no word at %0t", out_data, $time);
                end else begin
                    check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end else if (out_valid === 1'b0) begin
                check("idle_data", {24'd0, out_data}, 32'd0);
            end
        end
    end

    initial begin
        // first edge brings the DUT out of X
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // 1. reset held with in_valid high
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 2. single word
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 3. fill to full, fifth word refused, drain in order
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 4. full with both sides active: pop only, then in_ready returns
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h25, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // 5. streaming 20 words through, pointers wrap 5 times
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 6. reset with three words held, push+pop during reset ignored
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h34, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_byte_fifo
